// File: rtl/ul_pkg.sv
// Shared definitions for the uplink RBG power calculator: data widths,
// the symbol state enum, the per-RE control word and the output saturator.
package ul_pkg;

    localparam int RE_PER_PRB = 12;
    localparam int IQ_W       = 16;
    localparam int PWR_W      = 32;
    localparam int ACC_W      = 40;
    localparam int N_ANT      = 8;
    localparam int RBG_IDX_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } rbg_state_e;

    // Control word that travels alongside each RE through the square/sum stages.
    typedef struct packed {
        logic                 take;   // RE belongs to an active symbol
        logic                 start;  // first RE of a symbol: restart the sums
        logic                 close;  // last RE of an RBG: publish results
        logic                 err;    // symbol truncated by this RE's sop
        logic [RBG_IDX_W-1:0] idx;    // RBG this RE belongs to
    } rbg_ctl_t;

    // Shift the accumulated power down and clamp it to the output width.
    function automatic logic [PWR_W-1:0] sat_shift(input logic [ACC_W-1:0] acc,
                                                   input int unsigned      sh);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> sh;
        if (|shifted[ACC_W-1:PWR_W]) begin
            return '1;
        end
        return shifted[PWR_W-1:0];
    endfunction

endpackage

// File: rtl/ul_cplx_power.sv
// Two-stage registered |x|^2 of one IQ sample: stage 1 squares I and Q,
// stage 2 adds them. Pure datapath; validity is tracked by the caller.
module ul_cplx_power
    import ul_pkg::*;
(
    input  logic                clk,
    input  logic [2*IQ_W-1:0]   din_i,
    output logic [PWR_W-1:0]    pwr_o
);

    logic signed [IQ_W-1:0]  i_s;
    logic signed [IQ_W-1:0]  q_s;
    logic signed [PWR_W-1:0] i_ext;
    logic signed [PWR_W-1:0] q_ext;
    logic        [PWR_W-1:0] ii_q;
    logic        [PWR_W-1:0] qq_q;
    logic        [PWR_W-1:0] pwr_q;

    assign i_s   = din_i[2*IQ_W-1:IQ_W];
    assign q_s   = din_i[IQ_W-1:0];
    // Sign-extend before multiplying so the product is computed at full width.
    assign i_ext = PWR_W'(i_s);
    assign q_ext = PWR_W'(q_s);

    // Stage 1: square each component (max 2^30, always non-negative).
    // NOTE: pure datapath registers carry no reset; their contents are only
    // consumed when the matching control bit (which is reset) says so.
    always_ff @(posedge clk) begin
        ii_q <= $unsigned(i_ext * i_ext);
        qq_q <= $unsigned(q_ext * q_ext);
    end

    // Stage 2: I^2 + Q^2, max 2^31, fits unsigned 32 bits.
    always_ff @(posedge clk) begin
        pwr_q <= ii_q + qq_q;
    end

    assign pwr_o = pwr_q;

endmodule

// File: rtl/ul_rbg_power_calc.sv
// Per-antenna RBG power calculator. REs of a symbol are squared, summed over
// each RBG (12*PRB_PER_RBG REs, or up to eop) and published as a 32-bit
// saturated, right-shifted power. Pipeline: input reg, squares, sum,
// accumulate/close -> results 4 clocks after the closing RE.
module ul_rbg_power_calc
    import ul_pkg::*;
#(
    parameter int PRB_PER_RBG = 18,
    parameter int OUT_SHIFT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    input  logic                 i_sop,
    input  logic                 i_eop,
    input  logic [2*IQ_W-1:0]    i_din_ant0,
    input  logic [2*IQ_W-1:0]    i_din_ant1,
    input  logic [2*IQ_W-1:0]    i_din_ant2,
    input  logic [2*IQ_W-1:0]    i_din_ant3,
    input  logic [2*IQ_W-1:0]    i_din_ant4,
    input  logic [2*IQ_W-1:0]    i_din_ant5,
    input  logic [2*IQ_W-1:0]    i_din_ant6,
    input  logic [2*IQ_W-1:0]    i_din_ant7,
    output logic                 o_pwr_vld,
    output logic [RBG_IDX_W-1:0] o_rbg_idx,
    output logic [PWR_W-1:0]     o_ant_power0,
    output logic [PWR_W-1:0]     o_ant_power1,
    output logic [PWR_W-1:0]     o_ant_power2,
    output logic [PWR_W-1:0]     o_ant_power3,
    output logic [PWR_W-1:0]     o_ant_power4,
    output logic [PWR_W-1:0]     o_ant_power5,
    output logic [PWR_W-1:0]     o_ant_power6,
    output logic [PWR_W-1:0]     o_ant_power7,
    output logic                 o_sym_err
);

    localparam int RE_PER_RBG = RE_PER_PRB * PRB_PER_RBG;
    localparam int CNT_W      = (RE_PER_RBG > 1) ? $clog2(RE_PER_RBG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RE_PER_RBG - 1);

    // ------------------------------------------------------------------
    // Stage 0: input register
    // ------------------------------------------------------------------
    logic [2*IQ_W-1:0] din_a [N_ANT];
    logic [2*IQ_W-1:0] din_q [N_ANT];
    logic              vld_q;
    logic              sop_q;
    logic              eop_q;

    assign din_a[0] = i_din_ant0;
    assign din_a[1] = i_din_ant1;
    assign din_a[2] = i_din_ant2;
    assign din_a[3] = i_din_ant3;
    assign din_a[4] = i_din_ant4;
    assign din_a[5] = i_din_ant5;
    assign din_a[6] = i_din_ant6;
    assign din_a[7] = i_din_ant7;

    // Register the RE qualifiers; these are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
        end else begin
            vld_q <= i_vld;
            sop_q <= i_sop & i_vld;
            eop_q <= i_eop & i_vld;
        end
    end

    // Register the IQ samples of all antennas.
    always_ff @(posedge clk) begin
        for (int a = 0; a < N_ANT; a++) begin
            din_q[a] <= din_a[a];
        end
    end

    // ------------------------------------------------------------------
    // Stages 1-2: per-antenna I^2 + Q^2
    // ------------------------------------------------------------------
    logic [PWR_W-1:0] pwr_sq [N_ANT];

    for (genvar a = 0; a < N_ANT; a++) begin : g_ant
        ul_cplx_power u_cplx_power (
            .clk   (clk),
            .din_i (din_q[a]),
            .pwr_o (pwr_sq[a])
        );
    end

    // ------------------------------------------------------------------
    // Symbol FSM and RE/RBG counters (runs on the registered inputs)
    // ------------------------------------------------------------------
    rbg_state_e           state_q;
    logic [CNT_W-1:0]     re_cnt_q;
    logic [RBG_IDX_W-1:0] idx_q;
    rbg_ctl_t             ctl_q;
    rbg_ctl_t             ctl2_q;

    logic                 accept;
    logic                 close_now;
    logic [CNT_W-1:0]     cnt_cur;
    logic [RBG_IDX_W-1:0] idx_cur;

    // A sop always (re)starts a symbol at RE 0 of RBG 0; otherwise continue.
    assign accept    = vld_q & (sop_q | (state_q == ST_ACC));
    assign cnt_cur   = sop_q ? '0 : re_cnt_q;
    assign idx_cur   = sop_q ? '0 : idx_q;
    assign close_now = eop_q | (cnt_cur == CNT_MAX);

    // Track symbol state and RE position; emit a registered control word per RE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            re_cnt_q <= '0;
            idx_q    <= '0;
            ctl_q    <= '0;
        end else begin
            ctl_q.take  <= accept;
            ctl_q.start <= accept & sop_q;
            ctl_q.err   <= vld_q & sop_q & (state_q == ST_ACC);
            ctl_q.close <= accept & close_now;
            ctl_q.idx   <= idx_cur;
            if (accept) begin
                if (close_now) begin
                    re_cnt_q <= '0;
                    idx_q    <= idx_cur + 1'b1;
                end else begin
                    re_cnt_q <= cnt_cur + 1'b1;
                    idx_q    <= idx_cur;
                end
                state_q <= eop_q ? ST_IDLE : ST_ACC;
            end
        end
    end

    // Delay the control word one more stage to line up with the summed power.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl2_q <= '0;
        end else begin
            ctl2_q <= ctl_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: accumulate and close
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q     [N_ANT];
    logic [ACC_W-1:0] acc_sum   [N_ANT];
    logic [PWR_W-1:0] pwr_out_q [N_ANT];
    logic             pwr_vld_q;
    logic             sym_err_q;
    logic [RBG_IDX_W-1:0] rbg_idx_q;

    // Running sum including the current RE; a symbol start discards old partials.
    // NOTE: every element is assigned on every pass with blocking '=', so this
    // stays purely combinational and infers no latch.
    always_comb begin
        for (int a = 0; a < N_ANT; a++) begin
            acc_sum[a] = (ctl2_q.start ? '0 : acc_q[a]) + ACC_W'(pwr_sq[a]);
        end
    end

    // Update accumulators; on close publish saturated results and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_vld_q <= 1'b0;
            sym_err_q <= 1'b0;
            rbg_idx_q <= '0;
            for (int a = 0; a < N_ANT; a++) begin
                acc_q[a]     <= '0;
                pwr_out_q[a] <= '0;
            end
        end else begin
            pwr_vld_q <= ctl2_q.take & ctl2_q.close;
            sym_err_q <= ctl2_q.err;
            if (ctl2_q.take) begin
                if (ctl2_q.close) begin
                    rbg_idx_q <= ctl2_q.idx;
                    for (int a = 0; a < N_ANT; a++) begin
                        acc_q[a]     <= '0;
                        pwr_out_q[a] <= sat_shift(acc_sum[a], OUT_SHIFT);
                    end
                end else begin
                    for (int a = 0; a < N_ANT; a++) begin
                        acc_q[a] <= acc_sum[a];
                    end
                end
            end
        end
    end

    assign o_pwr_vld    = pwr_vld_q;
    assign o_sym_err    = sym_err_q;
    assign o_rbg_idx    = rbg_idx_q;
    assign o_ant_power0 = pwr_out_q[0];
    assign o_ant_power1 = pwr_out_q[1];
    assign o_ant_power2 = pwr_out_q[2];
    assign o_ant_power3 = pwr_out_q[3];
    assign o_ant_power4 = pwr_out_q[4];
    assign o_ant_power5 = pwr_out_q[5];
    assign o_ant_power6 = pwr_out_q[6];
    assign o_ant_power7 = pwr_out_q[7];

endmodule

// File: tb/tb_ul_rbg_power_calc.sv
// Directed bench for ul_rbg_power_calc: default instance plus an OUT_SHIFT=0
// instance on the same stimulus for the saturation case.
module tb_ul_rbg_power_calc;

    typedef struct {
        int              cyc;
        logic [3:0]      idx;
        logic [7:0][31:0] pwr;
    } pulse_t;

    typedef struct {
        int              cyc;
        logic [3:0]      idx;
        logic [7:0][31:0] p8;
        logic [7:0][31:0] p0;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             i_vld;
    logic             i_sop;
    logic             i_eop;
    logic [7:0][31:0] din;

    logic             o_pwr_vld;
    logic [3:0]       o_rbg_idx;
    logic [31:0]      o_ant_power0, o_ant_power1, o_ant_power2, o_ant_power3;
    logic [31:0]      o_ant_power4, o_ant_power5, o_ant_power6, o_ant_power7;
    logic             o_sym_err;

    logic             s_pwr_vld;
    logic [3:0]       s_rbg_idx;
    logic [31:0]      s_p0, s_p1, s_p2, s_p3, s_p4, s_p5, s_p6, s_p7;
    logic             s_sym_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int first_cyc;

    pulse_t           pq [$];
    logic [7:0][31:0] sq [$];
    exp_t             xq [$];
    int               eq [$];

    ul_rbg_power_calc dut (
        .clk          (clk),
        .rst          (rst),
        .i_vld        (i_vld),
        .i_sop        (i_sop),
        .i_eop        (i_eop),
        .i_din_ant0   (din[0]),
        .i_din_ant1   (din[1]),
        .i_din_ant2   (din[2]),
        .i_din_ant3   (din[3]),
        .i_din_ant4   (din[4]),
        .i_din_ant5   (din[5]),
        .i_din_ant6   (din[6]),
        .i_din_ant7   (din[7]),
        .o_pwr_vld    (o_pwr_vld),
        .o_rbg_idx    (o_rbg_idx),
        .o_ant_power0 (o_ant_power0),
        .o_ant_power1 (o_ant_power1),
        .o_ant_power2 (o_ant_power2),
        .o_ant_power3 (o_ant_power3),
        .o_ant_power4 (o_ant_power4),
        .o_ant_power5 (o_ant_power5),
        .o_ant_power6 (o_ant_power6),
        .o_ant_power7 (o_ant_power7),
        .o_sym_err    (o_sym_err)
    );

    ul_rbg_power_calc #(.PRB_PER_RBG(18), .OUT_SHIFT(0)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .i_vld        (i_vld),
        .i_sop        (i_sop),
        .i_eop        (i_eop),
        .i_din_ant0   (din[0]),
        .i_din_ant1   (din[1]),
        .i_din_ant2   (din[2]),
        .i_din_ant3   (din[3]),
        .i_din_ant4   (din[4]),
        .i_din_ant5   (din[5]),
        .i_din_ant6   (din[6]),
        .i_din_ant7   (din[7]),
        .o_pwr_vld    (s_pwr_vld),
        .o_rbg_idx    (s_rbg_idx),
        .o_ant_power0 (s_p0),
        .o_ant_power1 (s_p1),
        .o_ant_power2 (s_p2),
        .o_ant_power3 (s_p3),
        .o_ant_power4 (s_p4),
        .o_ant_power5 (s_p5),
        .o_ant_power6 (s_p6),
        .o_ant_power7 (s_p7),
        .o_sym_err    (s_sym_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record result and error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_pwr_vld) begin
            pq.push_back('{cyc, o_rbg_idx,
                           {o_ant_power7, o_ant_power6, o_ant_power5, o_ant_power4,
                            o_ant_power3, o_ant_power2, o_ant_power1, o_ant_power0}});
        end
        if (s_pwr_vld) begin
            sq.push_back({s_p7, s_p6, s_p5, s_p4, s_p3, s_p2, s_p1, s_p0});
        end
        if (o_sym_err) begin
            eq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_iq(input int mode, input int r, input int a);
        int i;
        int q;
        case (mode)
            0:       begin i = 100;    q = 0;      end
            1:       begin i = (a < 4) ? -32768 : 0; q = i; end
            2:       begin i = 0;      q = 200;    end
            default: begin
                i = ((r * 37 + a * 1013) % 4000) - 2000;
                q = ((r * 91 + a * 577) % 6000) - 3000;
            end
        endcase
        return {i[15:0], q[15:0]};
    endfunction

    function automatic longint re_pwr(input logic [31:0] d);
        longint i;
        longint q;
        i = $signed(d[31:16]);
        q = $signed(d[15:0]);
        return i * i + q * q;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic idle(input int n);
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one symbol of n REs and queue the expected RBG results.
    task automatic drive_sym(input int mode, input int n, input bit with_eop, input bit gaps);
        longint acc [8];
        int     rbg;
        bit     close;
        exp_t   x;
        rbg = 0;
        for (int a = 0; a < 8; a++) acc[a] = 0;
        for (int r = 0; r < n; r++) begin
            if (gaps) idle($urandom_range(0, 2));
            i_vld = 1'b1;
            i_sop = (r == 0);
            i_eop = with_eop && (r == n - 1);
            for (int a = 0; a < 8; a++) begin
                din[a] = gen_iq(mode, r, a);
                acc[a] += re_pwr(din[a]);
            end
            if (r == 0) first_cyc = cyc;
            close = ((r % 216) == 215) || (with_eop && (r == n - 1));
            if (close) begin
                x.cyc = cyc;
                x.idx = 4'(rbg);
                for (int a = 0; a < 8; a++) begin
                    x.p8[a] = sat32(acc[a] >>> 8);
                    x.p0[a] = sat32(acc[a]);
                    acc[a]  = 0;
                end
                xq.push_back(x);
                rbg++;
            end
            @(posedge clk);
            #1;
        end
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
    endtask

    // Match every queued expectation against the recorded pulses, in order.
    task automatic compare_all(input string tag);
        exp_t             x;
        pulse_t           p;
        logic [7:0][31:0] s;
        int               k;
        k = 0;
        while (xq.size() > 0) begin
            x = xq.pop_front();
            check($sformatf("%s_present%0d", tag, k), 64'(pq.size() != 0 && sq.size() != 0), 64'd1);
            if (pq.size() == 0 || sq.size() == 0) break;
            p = pq.pop_front();
            s = sq.pop_front();
            check($sformatf("%s_latency%0d", tag, k), 64'(p.cyc - x.cyc), 64'd4);
            check($sformatf("%s_idx%0d", tag, k), 64'(p.idx), 64'(x.idx));
            for (int a = 0; a < 8; a++) begin
                check($sformatf("%s_rbg%0d_ant%0d", tag, k, a), 64'(p.pwr[a]), 64'(x.p8[a]));
                check($sformatf("%s_sat_rbg%0d_ant%0d", tag, k, a), 64'(s[a]), 64'(x.p0[a]));
            end
            k++;
        end
        check({tag, "_extra_pulses"}, 64'(pq.size()), 64'd0);
        xq.delete();
        pq.delete();
        sq.delete();
    endtask

    initial begin
        rst   = 1'b1;
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
        din   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwr_vld", 64'(o_pwr_vld), 64'd0);
        check("rst_sym_err", 64'(o_sym_err), 64'd0);
        check("rst_rbg_idx", 64'(o_rbg_idx), 64'd0);
        check("rst_ant0",    64'(o_ant_power0), 64'd0);
        check("rst_ant7",    64'(o_ant_power7), 64'd0);
        rst = 1'b0;
        idle(2);

        // One full RBG, I=100 Q=0 -> 2160000 >> 8 = 8437
        drive_sym(0, 216, 1'b1, 1'b0);
        idle(8);
        check("rbg1_npulse", 64'(pq.size()), 64'd1);
        if (pq.size() > 0) begin
            check("rbg1_ant0_8437", 64'(pq[0].pwr[0]), 64'd8437);
            check("rbg1_ant6_8437", 64'(pq[0].pwr[6]), 64'd8437);
        end
        compare_all("rbg1");
        idle(20);
        check("hold_ant2", 64'(o_ant_power2), 64'd8437);
        check("hold_vld_low", 64'(o_pwr_vld), 64'd0);

        // 273 PRB symbol: 15 full RBGs plus a 36-RE tail, idx 0..15
        drive_sym(0, 3276, 1'b1, 1'b0);
        idle(8);
        check("sym273_npulse", 64'(pq.size()), 64'd16);
        if (pq.size() >= 16) begin
            check("sym273_rbg0", 64'(pq[0].pwr[0]), 64'd8437);
            check("sym273_rbg15", 64'(pq[15].pwr[7]), 64'd1406);
            check("sym273_idx15", 64'(pq[15].idx), 64'd15);
        end
        compare_all("sym273");

        // Saturation: I=Q=-32768 on ant0-3, zero on ant4-7
        drive_sym(1, 216, 1'b1, 1'b0);
        idle(8);
        if (sq.size() > 0 && pq.size() > 0) begin
            check("sat_ant0_max", 64'(sq[0][0]), 64'h0000_0000_FFFF_FFFF);
            check("sat_ant5_zero", 64'(sq[0][5]), 64'd0);
            check("sat_shift8_ant3", 64'(pq[0].pwr[3]), 64'd1811939328);
        end
        compare_all("sat");

        // One-RE symbol (sop and eop together): 10000 >> 8 = 39, rbg 0
        drive_sym(0, 1, 1'b1, 1'b0);
        idle(8);
        if (pq.size() > 0) check("one_re_ant5", 64'(pq[0].pwr[5]), 64'd39);
        compare_all("one_re");

        // Truncated symbol: 50 REs, then a new sop; only the new RBG reports
        eq.delete();
        drive_sym(0, 50, 1'b0, 1'b0);
        drive_sym(2, 216, 1'b1, 1'b0);
        idle(8);
        check("trunc_nerr", 64'(eq.size()), 64'd1);
        if (eq.size() > 0) check("trunc_err_latency", 64'(eq[0] - first_cyc), 64'd4);
        if (pq.size() > 0) check("trunc_ant1_33750", 64'(pq[0].pwr[1]), 64'd33750);
        compare_all("trunc");

        // REs in IDLE without sop are ignored
        eq.delete();
        i_vld = 1'b1;
        i_sop = 1'b0;
        for (int r = 0; r < 20; r++) begin
            i_eop = (r == 19);
            @(posedge clk);
            #1;
        end
        idle(8);
        check("nosop_npulse", 64'(pq.size()), 64'd0);
        check("nosop_nerr", 64'(eq.size()), 64'd0);

        // Reset right after a closing RE drops the in-flight result
        drive_sym(3, 100, 1'b1, 1'b1);
        rst = 1'b1;
        idle(2);
        check("midrst_pwr_vld", 64'(o_pwr_vld), 64'd0);
        check("midrst_ant1", 64'(o_ant_power1), 64'd0);
        check("midrst_sat_ant0", 64'(s_p0), 64'd0);
        rst = 1'b0;
        xq.delete();
        idle(10);
        check("midrst_npulse", 64'(pq.size()), 64'd0);

        // Clean gapped symbol after reset: 216 + 50 REs against the model
        eq.delete();
        drive_sym(3, 266, 1'b1, 1'b1);
        idle(8);
        check("post_rst_npulse", 64'(pq.size()), 64'd2);
        check("post_rst_nerr", 64'(eq.size()), 64'd0);
        compare_all("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ul_rbg_power_calc.md
UL_RBG_POWER_CALC -- requirements
Module: ul_rbg_power_calc

Interface
REQ-001 SHALL have parameter PRB_PER_RBG, default 18, meaning PRBs per RBG (12 RE per PRB, so 216 RE per RBG at default).
REQ-002 SHALL have parameter OUT_SHIFT, default 8, meaning right shift applied to the RBG power sum before output.
REQ-003 clk  input  1  single clock (491.52 MHz domain); all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_vld  input  1  RE valid; all antennas carry the same RE index.
REQ-006 i_sop  input  1  first RE of symbol; qualified by i_vld.
REQ-007 i_eop  input  1  last RE of symbol; qualified by i_vld.
REQ-008 i_din_ant0..i_din_ant7  input  32 each  IQ sample; I=[31:16], Q=[15:0], signed two's complement.
REQ-009 o_pwr_vld  output  1  one-cycle pulse; RBG power results updated.
REQ-010 o_rbg_idx  output  4  RBG index of current results.
REQ-011 o_ant_power0..o_ant_power7  output  32 each  per-antenna RBG power, unsigned.
REQ-012 o_sym_err  output  1  one-cycle pulse; symbol truncated (sop without preceding eop).

Function
REQ-013 Per RE and antenna, p = I*I + Q*Q, unsigned 32 bits; max 2^31, so no overflow.
REQ-014 Per antenna, a 40-bit accumulator sums p over the REs of one RBG; non-valid cycles do not change accumulators or counters.
REQ-015 RE counter 0..(12*PRB_PER_RBG-1); RBG closes on the valid RE where the counter hits its max, or on i_eop, whichever comes first.
REQ-016 On RBG close: result = min(acc >> OUT_SHIFT, 0xFFFFFFFF); o_ant_powerN, o_rbg_idx and o_pwr_vld update together.
REQ-017 Latency: o_pwr_vld asserts exactly 4 clk after the input cycle carrying the closing RE; pipeline = input reg, squares, sum, accumulate/close.
REQ-018 o_ant_powerN and o_rbg_idx hold their values between pulses.
REQ-019 RBG index is 0 at i_sop and increments after each close; it wraps modulo 16.
REQ-020 Accumulators and RE counter clear after each close; REs back-to-back across a close lose no sample.
REQ-021 States: IDLE (discard REs), ACC (accumulating). IDLE->ACC on vld&sop. ACC->IDLE on vld&eop.
REQ-022 vld&sop&eop in the same cycle: one-RE symbol; emit rbg 0 with that RE's power.
REQ-023 vld&sop while in ACC: o_sym_err pulses at the same latency as o_pwr_vld; partial sums are discarded with no o_pwr_vld; a new symbol starts with this RE.
REQ-024 REs arriving in IDLE without sop are ignored silently.

Reset
REQ-025 On rst, all outputs = 0, accumulators/counters = 0, state = IDLE, and pipeline valids are cleared.
REQ-026 Reset mid-symbol drops in-flight results; no o_pwr_vld until a new vld&sop RBG closes.

Structure
REQ-027 RE_PER_PRB (12), data widths (IQ 16, power 32, acc 40) and the state enum SHALL live in shared package ul_pkg.
REQ-028 One sub-module, ul_cplx_power (2-stage registered I^2+Q^2), is instantiated 8 times.

Verification
REQ-029 All ant I=100, Q=0, 216 RE in one symbol (sop first, eop last) -> single o_pwr_vld, rbg 0, power 8437 on all 8 antennas.
REQ-030 273 PRB (3276 RE), I=100, Q=0 -> 16 pulses (rbg 0..15); rbg 0..14 = 8437, rbg 15 (36 RE) = 1406.
REQ-031 OUT_SHIFT=0, I=Q=-32768 on 216 RE -> power 0xFFFFFFFF (saturated); ant with I=Q=0 -> 0.
REQ-032 Symbol with sop, 50 RE, then a new sop -> o_sym_err pulse, no o_pwr_vld for the 50 RE; next RBG result is correct.
REQ-033 Random vld gaps plus assert rst after RE 100 of an RBG -> outputs 0, no pulse; clean symbol afterwards gives results matching the reference model at 4-cycle latency.
